// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte stores to TX_ADDR are queued in a
// small FIFO and shifted out LSB first; STAT_ADDR reads back {overflow, full, busy}.
module uart_tx_mmio #(
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] TX_ADDR    = 32'h1000,
   parameter logic [31:0] STAT_ADDR  = 32'h1004
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wen,
   input  logic [31:0] i_addr_d,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_uart_out,
   output logic        o_busy,
   output logic        o_full
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          r_state, w_state_nxt;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wptr, r_rptr;
   logic [AW:0]     r_count;
   logic            r_ovf;
   logic [TW-1:0]   r_timer;
   logic [2:0]      r_bidx;
   logic [7:0]      r_shift;
   logic            r_txd;

   logic            w_full, w_empty, w_busy;
   logic            w_push, w_pop, w_tdone;
   logic            w_txd_nxt, w_shift_sh, w_bidx_clr, w_bidx_inc;
   logic            w_unused;

   assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_busy   = (r_state != S_IDLE) || !w_empty;
   assign w_tdone  = (r_timer == TW'(CLK_DIV - 1));
   // full is the pre-edge value, so a same-edge pop never rescues a store
   assign w_push   = i_wen && (i_addr_d == TX_ADDR) && !w_full;
   assign w_unused = ^i_wdata[31:8];

   assign o_rdata    = (i_addr_d == STAT_ADDR) ? {29'b0, r_ovf, w_full, w_busy} : 32'b0;
   assign o_uart_out = r_txd;
   assign o_busy     = w_busy;
   assign o_full     = w_full;

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata[7:0];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (i_wen && (i_addr_d == TX_ADDR) && w_full)
            r_ovf <= 1'b1;
         else if (i_wen && (i_addr_d == STAT_ADDR))
            r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (!w_empty) w_state_nxt = S_START;
         S_START: if (w_tdone)  w_state_nxt = S_DATA;
         S_DATA:  if (w_tdone && (r_bidx == 3'd7)) w_state_nxt = S_STOP;
         S_STOP:  if (w_tdone)  w_state_nxt = w_empty ? S_IDLE : S_START;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_pop      = 1'b0;
      w_txd_nxt  = r_txd;
      w_shift_sh = 1'b0;
      w_bidx_clr = 1'b0;
      w_bidx_inc = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop     = 1'b1;
               w_txd_nxt = 1'b0;
            end
         end
         S_START: begin
            if (w_tdone) begin
               w_txd_nxt  = r_shift[0];
               w_bidx_clr = 1'b1;
            end
         end
         S_DATA: begin
            if (w_tdone) begin
               if (r_bidx == 3'd7) begin
                  w_txd_nxt = 1'b1;
               end else begin
                  w_shift_sh = 1'b1;
                  w_txd_nxt  = r_shift[1];
                  w_bidx_inc = 1'b1;
               end
            end
         end
         S_STOP: begin
            // chain straight into the next start bit when more data is queued
            if (w_tdone && !w_empty) begin
               w_pop     = 1'b1;
               w_txd_nxt = 1'b0;
            end
         end
         default: w_txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_timer <= '0;
         r_bidx  <= '0;
         r_shift <= '0;
         r_txd   <= 1'b1;
      end else begin
         r_txd <= w_txd_nxt;
         if ((r_state == S_IDLE) || w_tdone) r_timer <= '0;
         else                                r_timer <= r_timer + 1'b1;
         if (w_bidx_clr)      r_bidx <= '0;
         else if (w_bidx_inc) r_bidx <= r_bidx + 1'b1;
         if (w_pop)           r_shift <= r_mem[r_rptr];
         else if (w_shift_sh) r_shift <= {1'b0, r_shift[7:1]};
      end
   end

endmodule
